// File: rtl/dcache_linefill.sv
// Purpose : data-cache line fill engine; fetches one line as a burst and writes it into byte-lane RAM banks.
// Latency : burst request the cycle after fill_req; each beat is written one cycle after it arrives;
//           fill_done pulses one cycle after the last write.
// Backpres: the request holds until mem_rd_ack; beats are taken whenever mem_rd_valid is high (no stall);
//           fill_req is only accepted while idle and is dropped, not queued, while busy.
//
// Ports:
//   clk, reset                    - clock and synchronous active-high reset
//   fill_req/fill_addr/fill_line  - start a fill of the line holding fill_addr into data-RAM line fill_line
//   fill_busy, fill_done          - engine not idle / one-cycle completion pulse
//   mem_rd_req/mem_addr/mem_rd_ack- line-aligned burst read request handshake
//   mem_rd_valid/mem_rd_data      - returned burst beats, lowest word first
//   ram_addr/ram_data/ram_we      - shared address, packed byte lanes and per-lane write enables of the RAM banks

module dcache_linefill #(
    parameter int LINEBITS = 2,
    parameter int WORDBITS = 3
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         fill_req,
    input  logic [31:0]                  fill_addr,
    input  logic [LINEBITS-1:0]          fill_line,
    output logic                         fill_busy,
    output logic                         fill_done,

    output logic                         mem_rd_req,
    output logic [31:0]                  mem_addr,
    input  logic                         mem_rd_ack,
    input  logic                         mem_rd_valid,
    input  logic [31:0]                  mem_rd_data,

    output logic [LINEBITS+WORDBITS-1:0] ram_addr,
    output logic [31:0]                  ram_data,
    output logic [3:0]                   ram_we
);

    // Byte offset within a line, and the tag bits that remain above it.
    localparam int OFFBITS  = 2 + WORDBITS;
    localparam int TAGBITS  = 32 - OFFBITS;
    localparam int RAMABITS = LINEBITS + WORDBITS;

    localparam logic [WORDBITS-1:0] LAST_WORD = '1;
    localparam logic [WORDBITS-1:0] ONE_WORD  = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_BEAT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;

    // Fill context captured at acceptance.
    logic [TAGBITS-1:0]    r_tag;
    logic [LINEBITS-1:0]   r_line;
    logic [WORDBITS-1:0]   r_cnt;
    // Set once the final beat has been captured; blocks any further captures
    // and lets the FSM leave BEAT only after that beat's write cycle.
    logic                  r_last;

    // Registered RAM write port: one cycle between beat arrival and write.
    logic                  r_ram_we;
    logic [RAMABITS-1:0]   r_ram_addr;
    logic [31:0]           r_ram_data;

    logic                  w_busy;
    logic                  w_done;
    logic                  w_rd_req;
    logic                  w_accept;
    logic                  w_capture;

    // Low address bits select bytes inside the line and play no part in the fill.
    logic                  w_unused_offset;
    assign w_unused_offset = ^fill_addr[OFFBITS-1:0];

    assign w_accept  = (r_state == S_IDLE) && fill_req;
    // Beats are only meaningful in BEAT; a valid coinciding with the ack, or
    // arriving after the last beat, falls outside this window and is dropped.
    assign w_capture = (r_state == S_BEAT) && mem_rd_valid && !r_last;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_busy   = 1'b1;
        w_done   = 1'b0;
        w_rd_req = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (fill_req) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                w_rd_req = 1'b1;
                if (mem_rd_ack) begin
                    w_next = S_BEAT;
                end
            end
            S_BEAT: begin
                // r_last is seen in the cycle the final beat is being written.
                if (r_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fill context, beat counter and RAM write register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag      <= '0;
            r_line     <= '0;
            r_cnt      <= '0;
            r_last     <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
        end else begin
            r_ram_we <= 1'b0;

            if (w_accept) begin
                r_tag  <= fill_addr[31:OFFBITS];
                r_line <= fill_line;
                r_cnt  <= '0;
                r_last <= 1'b0;
            end

            if (w_capture) begin
                r_ram_we   <= 1'b1;
                r_ram_addr <= {r_line, r_cnt};
                r_ram_data <= mem_rd_data;
                // The counter stops on the last word instead of wrapping, so a
                // stray beat can never address word 0 again.
                if (r_cnt == LAST_WORD) begin
                    r_last <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + ONE_WORD;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Reset forces every output low combinationally so a beat that
    // was registered just before reset is never written, and the interface
    // reads idle for the whole time reset is held.
    // ------------------------------------------------------------------
    assign fill_busy  = !reset && w_busy;
    assign fill_done  = !reset && w_done;
    assign mem_rd_req = !reset && w_rd_req;
    assign mem_addr   = reset ? 32'd0 : {r_tag, {OFFBITS{1'b0}}};
    assign ram_we     = reset ? 4'h0 : {4{r_ram_we}};
    assign ram_addr   = reset ? '0 : r_ram_addr;
    assign ram_data   = reset ? 32'd0 : r_ram_data;

endmodule

// File: tb/tb_dcache_linefill.sv
// Purpose : self-checking bench for dcache_linefill (cycle table plus multi-cycle sequences).
// Latency : n/a (bench).
// Backpres: n/a (bench).

module tb_dcache_linefill;

    logic        clk = 1'b0;
    logic        reset;
    logic        fill_req;
    logic [31:0] fill_addr;
    logic [1:0]  fill_line;
    logic        fill_busy;
    logic        fill_done;
    logic        mem_rd_req;
    logic [31:0] mem_addr;
    logic        mem_rd_ack;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic [4:0]  ram_addr;
    logic [31:0] ram_data;
    logic [3:0]  ram_we;

    always #5 clk = ~clk;

    dcache_linefill #(.LINEBITS(2), .WORDBITS(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .fill_req     (fill_req),
        .fill_addr    (fill_addr),
        .fill_line    (fill_line),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .mem_rd_req   (mem_rd_req),
        .mem_addr     (mem_addr),
        .mem_rd_ack   (mem_rd_ack),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_we       (ram_we)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle with the current inputs; returns at posedge+1.
    task automatic cyc();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Write/handshake monitor, sampled mid-cycle.
    // ------------------------------------------------------------------
    logic [36:0] wr_q[$];
    int cyc_no      = 0;
    int last_wr_cyc = 0;
    int done_cyc    = 0;
    int done_cnt    = 0;
    int req_cnt     = 0;
    int bad_we      = 0;
    logic prev_req  = 1'b0;

    always @(negedge clk) begin
        cyc_no++;
        if (ram_we != 4'h0) begin
            wr_q.push_back({ram_addr, ram_data});
            last_wr_cyc = cyc_no;
            if (ram_we !== 4'hF) bad_we++;
        end
        if (fill_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc_no;
        end
        if (mem_rd_req === 1'b1 && !prev_req) req_cnt++;
        prev_req = mem_rd_req;
    end

    task automatic clear_mon();
        wr_q.delete();
        done_cnt = 0;
        req_cnt  = 0;
        bad_we   = 0;
    endtask

    // ------------------------------------------------------------------
    // Cycle-by-cycle table: inputs for one cycle and the outputs expected
    // in that same cycle.
    // ------------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic        req;
        logic [31:0] addr;
        logic [1:0]  line;
        logic        ack;
        logic        vld;
        logic [31:0] dat;
        logic        e_busy;
        logic        e_done;
        logic        e_rdreq;
        logic [31:0] e_maddr;
        logic [3:0]  e_we;
        logic [4:0]  e_raddr;
        logic [31:0] e_rdat;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl[NVEC];

    function automatic vec_t mk(input logic rst, input logic req, input logic [31:0] addr,
                                input logic [1:0] line, input logic ack, input logic vld,
                                input logic [31:0] dat, input logic e_busy, input logic e_done,
                                input logic e_rdreq, input logic [31:0] e_maddr,
                                input logic [3:0] e_we, input logic [4:0] e_raddr,
                                input logic [31:0] e_rdat);
        vec_t v;
        v.rst = rst; v.req = req; v.addr = addr; v.line = line; v.ack = ack;
        v.vld = vld; v.dat = dat; v.e_busy = e_busy; v.e_done = e_done;
        v.e_rdreq = e_rdreq; v.e_maddr = e_maddr; v.e_we = e_we;
        v.e_raddr = e_raddr; v.e_rdat = e_rdat;
        return v;
    endfunction

    function automatic logic [31:0] td(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic build_table();
        //            rst req addr          ln ack vld dat            busy done rdq maddr         we    raddr dat
        tbl[0]  = mk(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        4'h0, 5'd0,  32'h0);
        tbl[1]  = mk(0, 1, 32'h0000_1234, 2, 0, 0, 32'h0,        0, 0, 0, 32'h0,        4'h0, 5'd0,  32'h0);
        tbl[2]  = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 1, 32'h0000_1220, 4'h0, 5'd0,  32'h0);
        tbl[3]  = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 1, 32'h0000_1220, 4'h0, 5'd0,  32'h0);
        tbl[4]  = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 1, 32'h0000_1220, 4'h0, 5'd0,  32'h0);
        // ack with a simultaneous valid: the valid must be dropped
        tbl[5]  = mk(0, 0, 32'h0,        0, 1, 1, 32'hDEAD_BEEF, 1, 0, 1, 32'h0000_1220, 4'h0, 5'd0,  32'h0);
        tbl[6]  = mk(0, 0, 32'h0,        0, 0, 1, td(0),        1, 0, 0, 32'h0000_1220, 4'h0, 5'd0,  32'h0);
        for (int k = 7; k <= 13; k++) begin
            tbl[k] = mk(0, 0, 32'h0, 0, 0, 1, td(k - 6), 1, 0, 0, 32'h0000_1220,
                        4'hF, 5'(16 + k - 7), td(k - 7));
        end
        // write of D7 while a stray extra valid arrives
        tbl[14] = mk(0, 0, 32'h0,        0, 0, 1, 32'hBAD0_BAD0, 1, 0, 0, 32'h0000_1220, 4'hF, 5'd23, td(7));
        // DONE: fill_req here must be ignored
        tbl[15] = mk(0, 1, 32'h0000_9999, 1, 0, 1, 32'hBAD1_BAD1, 1, 1, 0, 32'h0000_1220, 4'h0, 5'd23, td(7));
        tbl[16] = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_1220, 4'h0, 5'd23, td(7));
        tbl[17] = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_1220, 4'h0, 5'd23, td(7));
    endtask

    // ------------------------------------------------------------------
    // Complete fill with configurable ack delay, beat gap and noise
    // (valid with ack, fill_req mid-burst, valids after the last beat).
    // ------------------------------------------------------------------
    task automatic run_fill(input string tag, input logic [31:0] addr, input logic [1:0] line,
                            input int ack_dly, input int gap, input logic [31:0] d0, input bit noise);
        int n;
        logic [36:0] act;
        logic [2:0]  wi;
        logic [31:0] exp_maddr;
        exp_maddr = {addr[31:5], 5'b0};
        clear_mon();

        fill_req = 1'b1; fill_addr = addr; fill_line = line;
        cyc();
        fill_req = 1'b0; fill_addr = 32'h0; fill_line = 2'd0;

        n = 0;
        while (mem_rd_req !== 1'b1 && n < 10) begin cyc(); n++; end
        chk({tag, "_req_seen"}, 128'(mem_rd_req), 128'(1'b1));
        chk({tag, "_maddr"}, 128'(mem_addr), 128'(exp_maddr));

        repeat (ack_dly) cyc();
        chk({tag, "_req_stable"}, 128'({mem_rd_req, mem_addr}), 128'({1'b1, exp_maddr}));

        mem_rd_ack = 1'b1;
        if (noise) begin mem_rd_valid = 1'b1; mem_rd_data = 32'hBAD0_0000; end
        cyc();
        mem_rd_ack = 1'b0; mem_rd_valid = 1'b0;
        chk({tag, "_req_drop"}, 128'(mem_rd_req), 128'(1'b0));

        for (int i = 0; i < 8; i++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = d0 + 32'(i) * 32'h0101_0101;
            if (noise && i == 3) begin fill_req = 1'b1; fill_addr = 32'h5555_0000; fill_line = 2'd0; end
            cyc();
            mem_rd_valid = 1'b0; fill_req = 1'b0;
            repeat (gap) cyc();
        end
        if (noise) begin
            mem_rd_valid = 1'b1; mem_rd_data = 32'hBAD1_0000;
            cyc(); cyc();
            mem_rd_valid = 1'b0;
        end

        n = 0;
        while (fill_busy !== 1'b0 && n < 30) begin cyc(); n++; end
        chk({tag, "_end_idle"}, 128'(fill_busy), 128'(1'b0));
        repeat (3) cyc();

        chk({tag, "_done_cnt"}, 128'(done_cnt), 128'(1));
        chk({tag, "_done_gap"}, 128'(done_cyc - last_wr_cyc), 128'(1));
        chk({tag, "_req_cnt"}, 128'(req_cnt), 128'(1));
        chk({tag, "_wr_cnt"}, 128'(wr_q.size()), 128'(8));
        chk({tag, "_we_full"}, 128'(bad_we), 128'(0));
        for (int i = 0; i < 8; i++) begin
            wi  = i[2:0];
            act = (i < wr_q.size()) ? wr_q[i] : '1;
            chk($sformatf("%s_beat%0d", tag, i), 128'(act),
                128'({line, wi, d0 + 32'(i) * 32'h0101_0101}));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    initial begin
        logic [127:0] act;
        logic [127:0] exp;
        int n;

        reset = 1'b1; fill_req = 1'b0; fill_addr = 32'h0; fill_line = 2'd0;
        mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = 32'h0;
        build_table();
        @(posedge clk); #1;

        // ---------------- basic fill, cycle by cycle ----------------
        for (int v = 0; v < NVEC; v++) begin
            reset        = tbl[v].rst;
            fill_req     = tbl[v].req;
            fill_addr    = tbl[v].addr;
            fill_line    = tbl[v].line;
            mem_rd_ack   = tbl[v].ack;
            mem_rd_valid = tbl[v].vld;
            mem_rd_data  = tbl[v].dat;
            @(negedge clk);
            act = 128'({fill_busy, fill_done, mem_rd_req, mem_addr, ram_we, ram_addr, ram_data});
            exp = 128'({tbl[v].e_busy, tbl[v].e_done, tbl[v].e_rdreq, tbl[v].e_maddr,
                        tbl[v].e_we, tbl[v].e_raddr, tbl[v].e_rdat});
            chk($sformatf("vec[%0d]", v), act, exp);
            @(posedge clk); #1;
        end
        fill_req = 1'b0; mem_rd_ack = 1'b0; mem_rd_valid = 1'b0;
        cyc();

        // ---------------- gapped beats + byte lanes ----------------
        run_fill("gap", 32'h0000_ABCD, 2'd1, 1, 1, 32'hA1B2_C3D4, 1'b0);
        chk("lane3", 128'((wr_q.size() > 0) ? wr_q[0][31:24] : 8'h00), 128'(8'hA1));
        chk("lane0", 128'((wr_q.size() > 0) ? wr_q[0][7:0]   : 8'h00), 128'(8'hD4));

        // ---------------- ignored inputs ----------------
        run_fill("noise", 32'h8000_0FFF, 2'd3, 0, 0, 32'h1111_0000, 1'b1);

        // ---------------- reset at beat 4 ----------------
        clear_mon();
        fill_req = 1'b1; fill_addr = 32'h0000_0040; fill_line = 2'd3;
        cyc();
        fill_req = 1'b0;
        n = 0;
        while (mem_rd_req !== 1'b1 && n < 10) begin cyc(); n++; end
        chk("rst_req_seen", 128'(mem_rd_req), 128'(1'b1));
        mem_rd_ack = 1'b1;
        cyc();
        mem_rd_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rd_valid = 1'b1; mem_rd_data = 32'h7700_0000 + 32'(i);
            cyc();
        end
        reset = 1'b1; mem_rd_data = 32'h7700_0004;
        @(negedge clk);
        chk("rst_cycle_outs", 128'({ram_we, fill_busy, fill_done, mem_rd_req, mem_addr}), 128'(0));
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;
        cyc();
        reset = 1'b0;
        cyc(); cyc();
        chk("rst_after_outs", 128'({ram_we, fill_busy}), 128'(0));
        chk("rst_wr_cnt", 128'(wr_q.size()), 128'(3));
        chk("rst_last_wr", 128'((wr_q.size() > 0) ? wr_q[wr_q.size() - 1] : 37'h0),
            128'({2'd3, 3'd2, 32'h7700_0002}));

        run_fill("post_rst", 32'h0000_2000, 2'd0, 2, 0, 32'h0102_0304, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dcache_linefill.md
DCACHE_LINEFILL -- requirements
Module: dcache_linefill

Interface
REQ-001 Parameter LINEBITS, default 2, SHALL be the number of bits selecting the destination line (4 lines).
REQ-002 Parameter WORDBITS, default 3, SHALL be the number of bits selecting the 32-bit word within a line (8 words per line, 32 bytes).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-005 Port fill_req, input, 1, SHALL be the request to fill one line.
REQ-006 Port fill_addr, input, 32, SHALL be the byte address of the missing access.
REQ-007 Port fill_line, input, LINEBITS, SHALL be the destination line index in the data RAM.
REQ-008 Port fill_busy, output, 1, SHALL be high whenever the state is not IDLE.
REQ-009 Port fill_done, output, 1, SHALL be a one-cycle completion pulse.
REQ-010 Port mem_rd_req, output, 1, SHALL be the burst read request to memory.
REQ-011 Port mem_addr, output, 32, SHALL be the line-aligned burst start address.
REQ-012 Port mem_rd_ack, input, 1, SHALL indicate that memory accepted the request.
REQ-013 Port mem_rd_valid, input, 1, SHALL qualify mem_rd_data as one beat.
REQ-014 Port mem_rd_data, input, 32, SHALL be the returned word.
REQ-015 Port ram_addr, output, LINEBITS+WORDBITS, SHALL be the shared address of the four 8-bit byte-lane RAM banks.
REQ-016 Port ram_data, output, 32, SHALL carry byte lane n on bits [8n+7:8n].
REQ-017 Port ram_we, output, 4, SHALL be the per-byte-lane write enables.

Function
REQ-018 The block SHALL implement four states: IDLE, REQ, BEAT, and DONE.
REQ-019 In IDLE, fill_req=1 SHALL latch fill_addr[31:2+WORDBITS] and fill_line, clear the beat counter, and move to REQ on the next edge.
REQ-020 In REQ, mem_rd_req SHALL be 1 and mem_addr SHALL be {latched upper bits, (2+WORDBITS) zero bits}; both SHALL stay stable until mem_rd_ack=1.
REQ-021 When mem_rd_ack=1 in REQ, the block SHALL move to BEAT, with mem_rd_req=0 from the next cycle onward.
REQ-022 When mem_rd_valid=1 in BEAT, the block SHALL register the beat, and in the following cycle drive ram_we=4'hF, ram_data=captured word, and ram_addr={line, counter}.
REQ-023 The beat counter SHALL increment by 1 after each written beat, giving a write latency of exactly 1 cycle per beat.
REQ-024 Beats SHALL be written in ascending word order 0..2^WORDBITS-1.
REQ-025 Back-to-back valid beats SHALL produce back-to-back writes with no gaps.
REQ-026 After the write of the last beat (counter = 2^WORDBITS-1), the block SHALL enter DONE.
REQ-027 DONE SHALL assert fill_done=1 for exactly one cycle and return to IDLE; the counter SHALL NOT wrap into a further write.
REQ-028 ram_we SHALL be 0 in every cycle other than a beat write.
REQ-029 ram_addr and ram_data are don't-care when ram_we=0, but SHALL hold their last values.
REQ-030 fill_req while fill_busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-031 mem_rd_valid outside BEAT, including a valid in the same cycle as mem_rd_ack, SHALL be ignored.
REQ-032 mem_rd_valid received after the final beat SHALL be ignored.
REQ-033 fill_req accepted in the same cycle as fill_done SHALL NOT happen: fill_busy is high in DONE, and acceptance occurs only in IDLE.

Reset
REQ-034 While reset=1, the state SHALL be IDLE, the counter 0, and fill_busy=0, fill_done=0, mem_rd_req=0, mem_addr=0, ram_we=0, ram_addr=0, ram_data=0.
REQ-035 Reset asserted mid-fill SHALL abandon the fill, with no further RAM writes; any pending registered beat SHALL be discarded.

Verification
REQ-036 Basic fill: fill_addr=0x0000_1234, fill_line=2, ack after 3 cycles, 8 consecutive valid beats D0..D7 -> mem_addr=0x0000_1220; writes to ram_addr 16..23 with ram_we=4'hF, each one cycle after its beat; fill_done pulses one cycle after the last write.
REQ-037 Gapped beats: valid on alternate cycles -> exactly 8 writes, in order, no extra ram_we cycles.
REQ-038 Ignored inputs: fill_req pulsed during BEAT, and valid asserted with ack and again after the 8th beat -> no second request, no extra writes.
REQ-039 Reset at beat 4 -> ram_we=0 from the reset cycle onward; fill_busy=0; a new fill then completes normally on line 0 (ram_addr 0..7).
REQ-040 Byte lanes: beat data 0xA1B2C3D4 -> the bank-3 slice reads 0xA1 and the bank-0 slice reads 0xD4.
